reaction_ctrl: RTL
==================

# reaction_ctrl

Sequencing controller for the reaction tester. It takes a start request, samples the 10-bit LFSR value (`rand_num`) to choose a random fore-period, and lights the stimulus LED when that fore-period expires. It then measures in milliseconds the time until the button press and reports the result together with false-start and timeout status. It sits between the LFSR, the debounced push-button and the result/display logic.

## Interface
- `TICK_DIV`, 100000: clk cycles per 1 ms tick (100 MHz clock).
- `MIN_DELAY_MS`, 1000: fixed part of the fore-period, in ms.
- `TIMEOUT_MS`, 9999: maximum reaction time; reaching it ends the trial.
- `clk` input 1: system clock; every register is clocked on its rising edge.
- `rstn` input 1: reset. One clock; reset is asynchronous and active-low.
- `start` input 1: trial request; single-cycle pulse or level, sampled each cycle.
- `btn` input 1: debounced button level, already synchronous to `clk`.
- `rand_num` input 10: free-running LFSR value, range 1..1023.
- `led` output 1: stimulus LED, high only in GO.
- `busy` output 1: high in ARM, WAIT and GO.
- `done` output 1: one-cycle pulse when a trial ends, for any outcome.
- `early` output 1: sticky flag; the last trial was a false start.
- `timeout` output 1: sticky flag; the last trial reached `TIMEOUT_MS`.
- `result_ms` output 14: reaction time of the last valid trial, in ms.

## Operation
- Button edge: `btn_q` registers `btn`. A press is `btn & ~btn_q`. `btn_q` resets to 1 so that a button held through reset never produces a press.
- Prescaler: `pre` counts 0..TICK_DIV-1. `tick` is asserted when `pre == TICK_DIV-1`, after which `pre` wraps to 0. `pre` is cleared on every entry to WAIT and GO.
- `ms_cnt` (14 bits) counts ticks and is cleared on entry to WAIT and GO.
- IDLE / RESULT:
  - `start` → ARM. On this transition, clear `early` and `timeout`.
  - `result_ms` holds its value.
- ARM:
  - Wait until `btn == 0`.
  - Then latch `delay_ms = MIN_DELAY_MS + rand_num`. Width is 11 bits; the maximum value is 2023.
  - Go to WAIT.
- WAIT:
  - On `tick`, increment `ms_cnt`.
  - A press → RESULT with `early = 1`, `done` pulsed, `result_ms` unchanged.
  - When `tick` occurs with `ms_cnt == delay_ms-1` → GO.
  - If a press and fore-period expiry fall in the same cycle, the press wins (false start).
- GO:
  - `led = 1`.
  - A press → RESULT with `result_ms = ms_cnt`, `done` pulsed.
  - When `tick` occurs with `ms_cnt == TIMEOUT_MS-1` → RESULT with `timeout = 1`, `result_ms = TIMEOUT_MS`, `done` pulsed.
  - If a press and a tick fall in the same cycle, the press wins, and `result_ms` takes the un-incremented `ms_cnt`.
- `start` in ARM, WAIT or GO is ignored. `start` in RESULT begins a new trial.
- `rand_num` is sampled exactly once per trial, in the ARM cycle that latches `delay_ms`.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: `led = 0`, `busy = 0`, `done = 0`, `early = 0`, `timeout = 0`, `result_ms = 0`.
  - Counters: `pre = 0`, `ms_cnt = 0`, `delay_ms = 0`.
  - `btn_q = 1`.
- All outputs are registered.
- `start` at cycle n → `busy = 1` at n+1 (ARM). If `btn` is low, state is WAIT at n+2.
- Fore-period: exactly `delay_ms * TICK_DIV` cycles in WAIT, then `led` rises.
- Measurement:
  - A press first seen at `led`-rise + k cycles gives `result_ms = floor(k / TICK_DIV)`.
  - Measurement latency is 1 cycle from the press to `done`.
  - `result_ms` and the flags are valid in the same cycle as `done`.
  - `led` falls in the cycle `done` is high.
- Reset asserted mid-trial aborts immediately. No `done` pulse is emitted and the LED turns off asynchronously.

## Test plan
- Reset and idle: after reset with `btn = 1` held, all outputs are 0 and no `done` is produced. Then release `btn`; `btn` edges in IDLE do nothing.
- Normal trial (bench settings: `TICK_DIV=4`, `MIN_DELAY_MS=10`, `rand_num=5`):
  - `led` rises 60 cycles after WAIT entry.
  - A press 29 cycles after `led` rises gives `result_ms = 7` and a single `done` pulse.
- False start: with the same settings, a press at WAIT+20 → `early = 1`, `done` pulsed, `led` never rises, `result_ms` keeps its previous value.
- Timeout (bench setting `TIMEOUT_MS=8`): no press → `done` 32 cycles after `led` rises, `timeout = 1`, `result_ms = 8`.
- Collisions:
  - A press on the same cycle as a GO tick at `ms_cnt = 3` → `result_ms = 3`.
  - A press on the WAIT expiry cycle → `early = 1`.
- Control:
  - `start` pulses during WAIT and GO are ignored.
  - A new `start` in RESULT clears the flags.
  - `rstn` dropped in GO → `led = 0` at once and no `done`.
  - With `btn` held at `start`, the controller stays in ARM until `btn` is released.

Source files
------------

// File: rtl/reaction_ctrl.sv
// Reaction-tester sequencing controller: arms on start, waits a random
// fore-period, lights the LED, then times the button press in milliseconds.
module reaction_ctrl #(
  parameter int TICK_DIV     = 100000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int TIMEOUT_MS   = 9999
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        btn,
  input  logic [9:0]  rand_num,
  output logic        led,
  output logic        busy,
  output logic        done,
  output logic        early,
  output logic        timeout,
  output logic [13:0] result_ms
);

  localparam int               PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
  localparam logic [13:0]      TOUT_LAST = 14'(TIMEOUT_MS - 1);
  localparam logic [13:0]      TOUT_VAL  = 14'(TIMEOUT_MS);
  localparam logic [10:0]      MIN_DLY   = 11'(MIN_DELAY_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_GO,
    S_RESULT
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             btn_q;
  logic [PRE_W-1:0] pre;
  logic [13:0]      ms_cnt;
  logic [10:0]      delay_ms;

  logic             press;
  logic             tick;
  logic             expire;
  logic             gone_out;

  // one-cycle decisions produced by the next-state logic
  logic             enter_cnt;
  logic             latch_delay;
  logic             clr_flags;
  logic             end_early;
  logic             end_hit;
  logic             end_tout;

  // Fore-period in ms: fixed minimum plus the sampled LFSR value (max 2023).
  function automatic logic [10:0] fore_period(input logic [9:0] r);
    return MIN_DLY + {1'b0, r};
  endfunction

  assign press    = btn & ~btn_q;
  assign tick     = (pre == PRE_LAST);
  assign expire   = tick && (ms_cnt == ({3'b000, delay_ms} - 14'd1));
  assign gone_out = tick && (ms_cnt == TOUT_LAST);

  // State register; reset aborts any trial in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle control decisions; a press always beats a tick.
  always_comb begin
    state_nxt   = state;
    enter_cnt   = 1'b0;
    latch_delay = 1'b0;
    clr_flags   = 1'b0;
    end_early   = 1'b0;
    end_hit     = 1'b0;
    end_tout    = 1'b0;
    case (state)
      S_IDLE, S_RESULT: begin
        if (start) begin
          state_nxt = S_ARM;
          clr_flags = 1'b1;
        end
      end
      S_ARM: begin
        if (!btn) begin
          latch_delay = 1'b1;
          enter_cnt   = 1'b1;
          state_nxt   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (press) begin
          end_early = 1'b1;
          state_nxt = S_RESULT;
        end else if (expire) begin
          enter_cnt = 1'b1;
          state_nxt = S_GO;
        end
      end
      S_GO: begin
        if (press) begin
          end_hit   = 1'b1;
          state_nxt = S_RESULT;
        end else if (gone_out) begin
          end_tout  = 1'b1;
          state_nxt = S_RESULT;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Button history for edge detection; starts high so a held button is no press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_q <= 1'b1;
    end else begin
      btn_q <= btn;
    end
  end

  // Millisecond prescaler and counter, restarted on entry to WAIT and GO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre    <= '0;
      ms_cnt <= '0;
    end else if (enter_cnt) begin
      pre    <= '0;
      ms_cnt <= '0;
    end else if (state == S_WAIT || state == S_GO) begin
      if (tick) begin
        pre    <= '0;
        ms_cnt <= ms_cnt + 14'd1;
      end else begin
        pre    <= pre + PRE_ONE;
      end
    end
  end

  // Fore-period latch; rand_num is sampled only in the ARM cycle that leaves ARM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      delay_ms <= '0;
    end else if (latch_delay) begin
      delay_ms <= fore_period(rand_num);
    end
  end

  // Registered outputs, all derived from the decision made this cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      early     <= 1'b0;
      timeout   <= 1'b0;
      result_ms <= '0;
    end else begin
      led  <= (state_nxt == S_GO);
      busy <= (state_nxt == S_ARM) || (state_nxt == S_WAIT) || (state_nxt == S_GO);
      done <= end_early | end_hit | end_tout;
      if (clr_flags) begin
        early   <= 1'b0;
        timeout <= 1'b0;
      end
      if (end_early) begin
        early <= 1'b1;
      end
      if (end_tout) begin
        timeout   <= 1'b1;
        result_ms <= TOUT_VAL;
      end
      if (end_hit) begin
        result_ms <= ms_cnt;
      end
    end
  end

endmodule
